mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters SHALL be: MEM_LAT, default 2, memory access latency in cycles (legal range 1..15); STARVE_LIM, default 4, maximum consecutive D grants while I_REQ is pending.
REQ-002 CLK  input  1  clock; all state changes on posedge.
REQ-003 RSTn  input  1  reset, synchronous, active-low.
REQ-004 I_REQ  input  1  instruction-fetch request; held until I_GNT.
REQ-005 I_ADDR  input  12  fetch address; stable while I_REQ is high.
REQ-006 I_GNT  output  1  one-cycle grant pulse to I side.
REQ-007 I_VALID  output  1  one-cycle pulse; I_RDATA is valid.
REQ-008 I_RDATA  output  32  fetch data.
REQ-009 D_REQ  input  1  data-side (cache refill/writeback) request; held until D_GNT.
REQ-010 D_WE  input  1  1 = write, 0 = read.
REQ-011 D_ADDR  input  12  data address.
REQ-012 D_WDATA  input  32  write data.
REQ-013 D_BE  input  4  write byte enables.
REQ-014 D_GNT  output  1  one-cycle grant pulse to D side.
REQ-015 D_VALID  output  1  one-cycle completion pulse (read data or write ack).
REQ-016 D_RDATA  output  32  read data; 0 on write completion.
REQ-017 M_CSN  output  1  memory chip select, active-low.
REQ-018 M_WEN  output  1  memory write enable, active-low.
REQ-019 M_ADDR  output  12  memory address, passed unmodified.
REQ-020 M_DOUT  output  32  memory write data.
REQ-021 M_BE  output  4  memory byte enables.
REQ-022 M_DI  input  32  memory read data.

Function
REQ-023 FSM states SHALL be IDLE and ACCESS; a 4-bit counter cnt and a 1-bit owner register (I or D) SHALL be kept.
REQ-024 In IDLE at posedge, with any REQ high: the winner's address, data, BE and WE SHALL be latched; the FSM SHALL enter ACCESS; cnt SHALL load MEM_LAT-1; the winner's GNT SHALL be high for exactly the next cycle.
REQ-025 Arbitration: D SHALL win a simultaneous request unless starve==STARVE_LIM; in that case I SHALL win. I SHALL win when only I_REQ is high.
REQ-026 Starve counter: SHALL increment on each D grant while I_REQ is high; SHALL clear on I grant or when I_REQ is low in IDLE; SHALL saturate at STARVE_LIM.
REQ-027 In ACCESS: M_CSN=0; M_ADDR, M_DOUT and M_BE SHALL come from the latched values; M_WEN=0 only for D writes; M_BE SHALL be 4'b1111 for reads. In IDLE: M_CSN=1 and M_WEN=1.
REQ-028 In ACCESS with cnt!=0: cnt SHALL decrement at each posedge.
REQ-029 In ACCESS with cnt==0: at posedge, the owner's RDATA SHALL capture M_DI (D write: 0); the owner's VALID SHALL be high for the next cycle only; the FSM SHALL return to IDLE.
REQ-030 Latency: request sampled at edge k SHALL produce VALID during the cycle after edge k+MEM_LAT; M_CSN SHALL be low for exactly MEM_LAT cycles per access.
REQ-031 REQ inputs SHALL be ignored in ACCESS. A REQ high in IDLE SHALL be treated as a new request, including in the cycle VALID is high.
REQ-032 Non-owner RDATA SHALL hold its previous value. GNT and VALID SHALL never both be high on the same side in the same cycle.

Reset
REQ-033 When RSTn=0 at posedge: state IDLE, cnt=0, starve=0, all GNT/VALID=0, RDATA=0, M_CSN=1, M_WEN=1, M_ADDR=0, M_DOUT=0, M_BE=0.
REQ-034 Reset during ACCESS SHALL abort the access with no VALID pulse; the first grant SHALL occur no earlier than one cycle after RSTn returns high.

Verification
REQ-035 MEM_LAT=2; I_REQ, I_ADDR=0x010; M_DI=0xDEADBEEF -> I_GNT 1 cycle; M_CSN low for 2 cycles with M_ADDR=0x010; then I_VALID with I_RDATA=0xDEADBEEF.
REQ-036 I_REQ and D_REQ rise together; D_WE=1, D_ADDR=0x020, D_WDATA=0x12345678, D_BE=4'b0011 -> D served first: M_WEN=0, M_BE=4'b0011 for 2 cycles; D_VALID with D_RDATA=0; I granted on the next IDLE edge.
REQ-037 D_REQ re-asserted continuously with I_REQ held, STARVE_LIM=4 -> exactly 4 D grants, then I_GNT; starve returns to 0.
REQ-038 MEM_LAT=1 back-to-back I reads -> one access every 2 cycles; M_CSN low for 1 cycle each.
REQ-039 RSTn low on the second ACCESS cycle of a D read -> no D_VALID; all outputs at reset values; a new I_REQ is granted normally afterward.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - I-side, D-side and memory signals of the memory port arbiter
interface mem_port_arbiter_if;
  logic        I_REQ;
  logic [11:0] I_ADDR;
  logic        I_GNT;
  logic        I_VALID;
  logic [31:0] I_RDATA;

  logic        D_REQ;
  logic        D_WE;
  logic [11:0] D_ADDR;
  logic [31:0] D_WDATA;
  logic [3:0]  D_BE;
  logic        D_GNT;
  logic        D_VALID;
  logic [31:0] D_RDATA;

  logic        M_CSN;
  logic        M_WEN;
  logic [11:0] M_ADDR;
  logic [31:0] M_DOUT;
  logic [3:0]  M_BE;
  logic [31:0] M_DI;

  // Arbiter side
  modport slave (
    input  I_REQ, I_ADDR,
    output I_GNT, I_VALID, I_RDATA,
    input  D_REQ, D_WE, D_ADDR, D_WDATA, D_BE,
    output D_GNT, D_VALID, D_RDATA,
    output M_CSN, M_WEN, M_ADDR, M_DOUT, M_BE,
    input  M_DI
  );

  // Requester / memory model side
  modport master (
    output I_REQ, I_ADDR,
    input  I_GNT, I_VALID, I_RDATA,
    output D_REQ, D_WE, D_ADDR, D_WDATA, D_BE,
    input  D_GNT, D_VALID, D_RDATA,
    input  M_CSN, M_WEN, M_ADDR, M_DOUT, M_BE,
    output M_DI
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester single-port memory arbiter with D priority and I starvation guard
module mem_port_arbiter #(
  parameter int MEM_LAT    = 2,
  parameter int STARVE_LIM = 4
) (
  input  logic              CLK,
  input  logic              RSTn,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  localparam logic [3:0] LP_CNT_LOAD   = 4'(MEM_LAT - 1);
  localparam logic [7:0] LP_STARVE_LIM = 8'(STARVE_LIM);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_owner_d;
  logic        r_we;
  logic [7:0]  r_starve;

  logic        r_i_gnt;
  logic        r_i_valid;
  logic [31:0] r_i_rdata;
  logic        r_d_gnt;
  logic        r_d_valid;
  logic [31:0] r_d_rdata;
  logic        r_m_csn;
  logic        r_m_wen;
  logic [11:0] r_m_addr;
  logic [31:0] r_m_dout;
  logic [3:0]  r_m_be;

  logic        w_any_req;
  logic        w_d_wins;

  assign w_any_req = bus.I_REQ | bus.D_REQ;
  // D has priority unless I has been passed over STARVE_LIM times in a row
  assign w_d_wins  = bus.D_REQ & ~(bus.I_REQ & (r_starve == LP_STARVE_LIM));

  // Arbitration FSM: grant and latch in IDLE, count down latency in ACCESS, then complete
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 4'd0;
      r_owner_d <= 1'b0;
      r_we      <= 1'b0;
      r_starve  <= 8'd0;
      r_i_gnt   <= 1'b0;
      r_i_valid <= 1'b0;
      r_i_rdata <= 32'd0;
      r_d_gnt   <= 1'b0;
      r_d_valid <= 1'b0;
      r_d_rdata <= 32'd0;
      r_m_csn   <= 1'b1;
      r_m_wen   <= 1'b1;
      r_m_addr  <= 12'd0;
      r_m_dout  <= 32'd0;
      r_m_be    <= 4'd0;
    end else begin
      r_i_gnt   <= 1'b0;
      r_d_gnt   <= 1'b0;
      r_i_valid <= 1'b0;
      r_d_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!bus.I_REQ) begin
            r_starve <= 8'd0;
          end
          if (w_any_req) begin
            r_state   <= ST_ACCESS;
            r_cnt     <= LP_CNT_LOAD;
            r_m_csn   <= 1'b0;
            r_owner_d <= w_d_wins;
            if (w_d_wins) begin
              r_d_gnt  <= 1'b1;
              r_we     <= bus.D_WE;
              r_m_wen  <= ~bus.D_WE;
              r_m_addr <= bus.D_ADDR;
              r_m_dout <= bus.D_WDATA;
              r_m_be   <= bus.D_WE ? bus.D_BE : 4'b1111;
              if (bus.I_REQ && (r_starve != LP_STARVE_LIM)) begin
                r_starve <= r_starve + 8'd1;
              end
            end else begin
              r_i_gnt  <= 1'b1;
              r_we     <= 1'b0;
              r_m_wen  <= 1'b1;
              r_m_addr <= bus.I_ADDR;
              r_m_dout <= 32'd0;
              r_m_be   <= 4'b1111;
              r_starve <= 8'd0;
            end
          end
        end
        ST_ACCESS: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_state <= ST_IDLE;
            r_m_csn <= 1'b1;
            r_m_wen <= 1'b1;
            if (r_owner_d) begin
              r_d_valid <= 1'b1;
              r_d_rdata <= r_we ? 32'd0 : bus.M_DI;
            end else begin
              r_i_valid <= 1'b1;
              r_i_rdata <= bus.M_DI;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.I_GNT   = r_i_gnt;
  assign bus.I_VALID = r_i_valid;
  assign bus.I_RDATA = r_i_rdata;
  assign bus.D_GNT   = r_d_gnt;
  assign bus.D_VALID = r_d_valid;
  assign bus.D_RDATA = r_d_rdata;
  assign bus.M_CSN   = r_m_csn;
  assign bus.M_WEN   = r_m_wen;
  assign bus.M_ADDR  = r_m_addr;
  assign bus.M_DOUT  = r_m_dout;
  assign bus.M_BE    = r_m_be;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic CLK;
  logic RSTn;
  int   n_checks;
  int   n_errors;

  mem_port_arbiter_if b2();
  mem_port_arbiter_if b1();

  mem_port_arbiter #(.MEM_LAT(2), .STARVE_LIM(4)) u_dut2 (
    .CLK  (CLK),
    .RSTn (RSTn),
    .bus  (b2.slave)
  );

  mem_port_arbiter #(.MEM_LAT(1), .STARVE_LIM(4)) u_dut1 (
    .CLK  (CLK),
    .RSTn (RSTn),
    .bus  (b1.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int d_grants;
    bit i_seen;
    bit g_seen;

    n_checks = 0;
    n_errors = 0;
    RSTn = 1'b0;
    b2.I_REQ = 0; b2.I_ADDR = '0; b2.D_REQ = 0; b2.D_WE = 0;
    b2.D_ADDR = '0; b2.D_WDATA = '0; b2.D_BE = '0; b2.M_DI = '0;
    b1.I_REQ = 0; b1.I_ADDR = '0; b1.D_REQ = 0; b1.D_WE = 0;
    b1.D_ADDR = '0; b1.D_WDATA = '0; b1.D_BE = '0; b1.M_DI = '0;

    // Reset state
    tick(); tick();
    check("rst_i_gnt",   b2.I_GNT,   0);
    check("rst_d_gnt",   b2.D_GNT,   0);
    check("rst_i_valid", b2.I_VALID, 0);
    check("rst_d_valid", b2.D_VALID, 0);
    check("rst_i_rdata", b2.I_RDATA, 0);
    check("rst_d_rdata", b2.D_RDATA, 0);
    check("rst_m_csn",   b2.M_CSN,   1);
    check("rst_m_wen",   b2.M_WEN,   1);
    check("rst_m_addr",  b2.M_ADDR,  0);
    check("rst_m_dout",  b2.M_DOUT,  0);
    check("rst_m_be",    b2.M_BE,    0);
    RSTn = 1'b1;
    tick();
    check("idle_no_gnt", b2.I_GNT | b2.D_GNT, 0);

    // Single I read, MEM_LAT=2
    b2.I_REQ = 1; b2.I_ADDR = 12'h010; b2.M_DI = 32'hDEADBEEF;
    tick();
    check("t1_i_gnt",  b2.I_GNT,  1);
    check("t1_csn0",   b2.M_CSN,  0);
    check("t1_addr",   b2.M_ADDR, 12'h010);
    check("t1_wen",    b2.M_WEN,  1);
    check("t1_be",     b2.M_BE,   4'hF);
    b2.I_REQ = 0;
    tick();
    check("t1_gnt_one_cycle", b2.I_GNT, 0);
    check("t1_csn1",   b2.M_CSN,  0);
    check("t1_novalid_yet", b2.I_VALID, 0);
    tick();
    check("t1_i_valid", b2.I_VALID, 1);
    check("t1_i_rdata", b2.I_RDATA, 32'hDEADBEEF);
    check("t1_csn_off", b2.M_CSN,  1);
    tick();
    check("t1_valid_one_cycle", b2.I_VALID, 0);
    check("t1_rdata_hold", b2.I_RDATA, 32'hDEADBEEF);

    // Simultaneous I and D write: D first, then I
    b2.I_REQ = 1; b2.I_ADDR = 12'h030;
    b2.D_REQ = 1; b2.D_WE = 1; b2.D_ADDR = 12'h020;
    b2.D_WDATA = 32'h12345678; b2.D_BE = 4'b0011; b2.M_DI = 32'hCAFEF00D;
    tick();
    check("t2_d_gnt",  b2.D_GNT,  1);
    check("t2_i_nogn", b2.I_GNT,  0);
    check("t2_wen0",   b2.M_WEN,  0);
    check("t2_be",     b2.M_BE,   4'b0011);
    check("t2_addr",   b2.M_ADDR, 12'h020);
    check("t2_dout",   b2.M_DOUT, 32'h12345678);
    b2.D_REQ = 0;
    tick();
    check("t2_wen0_c2", b2.M_WEN, 0);
    check("t2_csn0_c2", b2.M_CSN, 0);
    tick();
    check("t2_d_valid", b2.D_VALID, 1);
    check("t2_d_rdata", b2.D_RDATA, 0);
    check("t2_wen_off", b2.M_WEN,   1);
    check("t2_i_hold",  b2.I_RDATA, 32'hDEADBEEF);
    tick();
    check("t2_i_gnt",   b2.I_GNT,   1);
    check("t2_i_addr",  b2.M_ADDR,  12'h030);
    check("t2_i_be",    b2.M_BE,    4'hF);
    check("t2_d_vdone", b2.D_VALID, 0);
    b2.I_REQ = 0;
    tick(); tick();
    check("t2_i_valid", b2.I_VALID, 1);
    check("t2_i_rdata", b2.I_RDATA, 32'hCAFEF00D);
    check("t2_d_hold",  b2.D_RDATA, 0);
    tick();

    // Starvation guard: 4 D grants then I
    b2.I_REQ = 1; b2.I_ADDR = 12'h040;
    b2.D_REQ = 1; b2.D_WE = 0; b2.D_ADDR = 12'h050; b2.M_DI = 32'h11112222;
    d_grants = 0;
    i_seen = 0;
    for (int c = 0; c < 40 && !i_seen; c++) begin
      tick();
      if (b2.D_GNT) d_grants++;
      if (b2.I_GNT) i_seen = 1;
      if (b2.D_VALID) check("t3_d_rdata", b2.D_RDATA, 32'h11112222);
    end
    check("t3_i_granted", i_seen, 1);
    check("t3_d_grants",  d_grants, 4);
    g_seen = 0;
    for (int c = 0; c < 10 && !g_seen; c++) begin
      tick();
      if (b2.I_VALID) check("t3_i_rdata", b2.I_RDATA, 32'h11112222);
      if (b2.I_GNT | b2.D_GNT) begin
        g_seen = 1;
        check("t3_next_is_d", {b2.I_GNT, b2.D_GNT}, 2'b01);
      end
    end
    check("t3_next_grant_seen", g_seen, 1);
    b2.I_REQ = 0; b2.D_REQ = 0;
    tick(); tick(); tick(); tick();
    check("t3_drained", b2.M_CSN, 1);

    // Reset during second ACCESS cycle of a D read
    b2.D_REQ = 1; b2.D_WE = 0; b2.D_ADDR = 12'h0AB; b2.M_DI = 32'h55AA55AA;
    tick();
    check("t4_d_gnt", b2.D_GNT, 1);
    b2.D_REQ = 0;
    tick();
    RSTn = 1'b0;
    tick();
    check("t4_no_valid", b2.D_VALID, 0);
    check("t4_csn",      b2.M_CSN,   1);
    check("t4_wen",      b2.M_WEN,   1);
    check("t4_addr",     b2.M_ADDR,  0);
    check("t4_be",       b2.M_BE,    0);
    check("t4_d_rdata",  b2.D_RDATA, 0);
    check("t4_i_rdata",  b2.I_RDATA, 0);
    RSTn = 1'b1;
    tick();
    check("t4_no_valid_after", b2.D_VALID, 0);
    b2.I_REQ = 1; b2.I_ADDR = 12'h0CD; b2.M_DI = 32'h0BADCAFE;
    tick();
    check("t4_i_gnt",  b2.I_GNT,  1);
    check("t4_i_addr", b2.M_ADDR, 12'h0CD);
    b2.I_REQ = 0;
    tick(); tick();
    check("t4_i_valid", b2.I_VALID, 1);
    check("t4_i_rdata", b2.I_RDATA, 32'h0BADCAFE);

    // MEM_LAT=1 back-to-back I reads: one access every two cycles
    b1.I_REQ = 1; b1.I_ADDR = 12'h100; b1.M_DI = 32'hA5A5A5A5;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("t5_i_gnt",   b1.I_GNT,   (i % 2 == 0) ? 1 : 0);
      check("t5_csn",     b1.M_CSN,   (i % 2 == 0) ? 0 : 1);
      check("t5_i_valid", b1.I_VALID, (i % 2 == 0) ? 0 : 1);
      if (i % 2 == 1) check("t5_i_rdata", b1.I_RDATA, 32'hA5A5A5A5);
    end
    b1.I_REQ = 0;
    tick(); tick();
    check("t5_idle", b1.M_CSN, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
